vector_exec_mem_unit: RTL and testbench

VECTOR_EXEC_MEM_UNIT -- requirements
Module: vector_exec_mem_unit

---
 rtl/vector_exec_mem_unit.sv | 106 ++++++++++
 tb/tb_vector_exec_mem_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vector_exec_mem_unit.sv
// Vector execute/memory unit: R-lane ALU with vector/scalar/immediate operand B, effective-address adder,
// and a byte-addressed wrap-around data memory (D must be a power of two). Define VEC_MUL_EN to include the lane multiplier.
module vector_exec_mem_unit #(
   parameter int R = 6,
   parameter int N = 8,
   parameter int I = 32,
   parameter int D = 256
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [R-1:0][N-1:0]   SrcAE,
   input  logic [R-1:0][N-1:0]   SrcBE,
   input  logic [3:0]            SrcBiE,
   input  logic [N-1:0]          Imm,
   input  logic [1:0]            VSIFlag,
   input  logic [2:0]            ALUControl,
   output logic [R-1:0][N-1:0]   ALUOutput,
   output logic [R-1:0][1:0]     ALUFlags,
   output logic [I-1:0]          A,
   input  logic                  WE,
   input  logic [I-1:0]          MA,
   input  logic [R-1:0][N-1:0]   WD,
   output logic [R-1:0][N-1:0]   RD
);

   localparam int AW = $clog2(D);

   logic [4*N-1:0]        addr_base_s;
   logic [N-1:0]          opb_bcast_s;
   logic [R-1:0][N-1:0]   opb_s;
   logic [R-1:0][N-1:0]   res_s;
   logic [AW-1:0]         base_idx_s;
   logic [N-1:0]          mem_q [D];
   logic [N-1:0]          mem_d [D];
   logic                  unused_ok_s;

   assign addr_base_s = {SrcAE[3], SrcAE[2], SrcAE[1], SrcAE[0]};
   assign A           = I'(addr_base_s) + I'(Imm);
   assign base_idx_s  = MA[AW-1:0];
   assign unused_ok_s = ^{MA, SrcBiE[3]};

   // Scalar-mode lane pick; an index with no matching lane falls back to lane 0.
   always_comb begin
      opb_bcast_s = SrcBE[0];
      for (int k = 0; k < R; k++) begin
         opb_bcast_s = (int'(SrcBiE[2:0]) == k) ? SrcBE[k] : opb_bcast_s;
      end
   end

   always_comb begin
      for (int i = 0; i < R; i++) begin
         case (VSIFlag)
            2'b00:   opb_s[i] = SrcBE[i];
            2'b01:   opb_s[i] = opb_bcast_s;
            default: opb_s[i] = Imm;
         endcase

         case (ALUControl)
            3'b000:  res_s[i] = SrcAE[i] + opb_s[i];
            3'b001:  res_s[i] = SrcAE[i] - opb_s[i];
`ifdef VEC_MUL_EN
            3'b010:  res_s[i] = N'(SrcAE[i] * opb_s[i]);
`else
            3'b010:  res_s[i] = '0;
`endif
            3'b011:  res_s[i] = SrcAE[i] & opb_s[i];
            3'b100:  res_s[i] = SrcAE[i] | opb_s[i];
            3'b101:  res_s[i] = SrcAE[i] ^ opb_s[i];
            3'b110:  res_s[i] = SrcAE[i] << opb_s[i][2:0];
            default: res_s[i] = SrcAE[i] >> opb_s[i][2:0];
         endcase

         ALUOutput[i] = res_s[i];
         ALUFlags[i]  = {res_s[i][N-1], (res_s[i] == {N{1'b0}})};
      end
   end

   // Lane addresses wrap naturally through the AW-bit index arithmetic.
   always_comb begin
      mem_d = mem_q;
      if (WE) begin
         for (int k = 0; k < R; k++) begin
            mem_d[base_idx_s + AW'(k)] = WD[k];
         end
      end else begin
         mem_d = mem_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < D; k++) begin
            mem_q[k] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      for (int k = 0; k < R; k++) begin
         RD[k] = mem_q[base_idx_s + AW'(k)];
      end
   end

endmodule

// File: tb/tb_vector_exec_mem_unit.sv
// Scoreboard bench for vector_exec_mem_unit: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_vector_exec_mem_unit;
   localparam int R = 6;
   localparam int N = 8;
   localparam int I = 32;
   localparam int D = 256;

   typedef logic [R-1:0][N-1:0] vec_t;
   typedef struct {
      vec_t                out;
      logic [R-1:0][1:0]   flg;
      logic [I-1:0]        a;
      vec_t                rd;
      bit                  chk_rd;
      string               name;
   } exp_t;

   logic               clk = 1'b0;
   logic               reset;
   vec_t               SrcAE, SrcBE, WD, ALUOutput, RD;
   logic [3:0]         SrcBiE;
   logic [N-1:0]       Imm;
   logic [1:0]         VSIFlag;
   logic [2:0]         ALUControl;
   logic [R-1:0][1:0]  ALUFlags;
   logic [I-1:0]       A, MA;
   logic               WE;

   int   checks = 0;
   int   errors = 0;
   bit   tb_valid = 1'b0;
   exp_t sb_q[$];
   int   ref_mem [D];

   vector_exec_mem_unit #(.R(R), .N(N), .I(I), .D(D)) dut (
      .clk(clk), .reset(reset), .SrcAE(SrcAE), .SrcBE(SrcBE), .SrcBiE(SrcBiE),
      .Imm(Imm), .VSIFlag(VSIFlag), .ALUControl(ALUControl), .ALUOutput(ALUOutput),
      .ALUFlags(ALUFlags), .A(A), .WE(WE), .MA(MA), .WD(WD), .RD(RD)
   );

   always #5 clk = ~clk;

   function automatic int lane_op(int op, int a, int b);
      int r;
      case (op)
         0: r = a + b;
         1: r = a - b;
         2: begin
`ifdef VEC_MUL_EN
            r = a * b;
`else
            r = 0;
`endif
         end
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = a << (b % 8);
         7: r = a >> (b % 8);
         default: r = 0;
      endcase
      return r & ((1 << N) - 1);
   endfunction

   task automatic chk(input string nm, input string fld, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s %s: got %h expected %h", nm, fld, got, exp);
      end
   endtask

   task automatic issue(input vec_t sa, input vec_t sb, input logic [3:0] bi, input logic [N-1:0] im,
                        input logic [1:0] vsi, input logic [2:0] op, input logic we_i,
                        input logic [I-1:0] ma_i, input vec_t wd_i, input logic rst_i, input string nm);
      exp_t   e;
      int     b, idx, r;
      longint base;
      @(posedge clk);
      #1;
      SrcAE = sa; SrcBE = sb; SrcBiE = bi; Imm = im; VSIFlag = vsi; ALUControl = op;
      WE = we_i; MA = ma_i; WD = wd_i; reset = rst_i;
      for (int i = 0; i < R; i++) begin
         if (vsi == 2'b00) b = int'(sb[i]);
         else if (vsi == 2'b01) begin
            idx = int'(bi) % 8;
            if (idx >= R) idx = 0;
            b = int'(sb[idx]);
         end else b = int'(im);
         r = lane_op(int'(op), int'(sa[i]), b);
         e.out[i] = r[N-1:0];
         e.flg[i] = {r[N-1], (r == 0)};
         e.rd[i]  = ref_mem[(int'(ma_i % D) + i) % D][N-1:0];
      end
      base = 0;
      for (int k = 0; k < 4; k++) base += longint'(sa[k]) << (N * k);
      base = (base + longint'(im)) % (64'sd1 <<< I);
      e.a = base[I-1:0];
      e.chk_rd = 1'b1;
      e.name = nm;
      sb_q.push_back(e);
      tb_valid = 1'b1;
      if (rst_i) begin
         for (int k = 0; k < D; k++) ref_mem[k] = 0;
      end else if (we_i) begin
         for (int i = 0; i < R; i++) ref_mem[(int'(ma_i % D) + i) % D] = int'(wd_i[i]);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (tb_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: output presented with empty queue");
         end else begin
            e = sb_q.pop_front();
            chk(e.name, "ALUOutput", 64'(ALUOutput), 64'(e.out));
            chk(e.name, "ALUFlags", 64'(ALUFlags), 64'(e.flg));
            chk(e.name, "A", 64'(A), 64'(e.a));
            if (e.chk_rd) chk(e.name, "RD", 64'(RD), 64'(e.rd));
         end
      end
   end

   function automatic vec_t rvec();
      vec_t v;
      for (int i = 0; i < R; i++) v[i] = N'($urandom);
      return v;
   endfunction

   function automatic vec_t fill(input logic [N-1:0] x);
      vec_t v;
      for (int i = 0; i < R; i++) v[i] = x;
      return v;
   endfunction

   initial begin
      vec_t sa, sb, wd;
      logic [I-1:0] ma, last_ma;
      reset = 1'b1; SrcAE = '0; SrcBE = '0; SrcBiE = 4'd0; Imm = '0; VSIFlag = 2'b00;
      ALUControl = 3'b000; WE = 1'b0; MA = '0; WD = '0;
      for (int k = 0; k < D; k++) ref_mem[k] = 0;

      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_0000, '0, 1'b0, "reset_rd0");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_0080, '0, 1'b0, "reset_rd80");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_00FD, '0, 1'b0, "reset_rdFD");

      for (int i = 0; i < R; i++) sa[i] = N'(i + 1);
      issue(sa, '0, 4'd0, 8'd5, 2'b11, 3'b000, 1'b0, 32'h0, '0, 1'b0, "vec_imm_add");
      sa = '0; sa[0] = 8'h10;
      issue(sa, '0, 4'd0, 8'd5, 2'b10, 3'b011, 1'b0, 32'h0, '0, 1'b0, "addr_0x15");
      issue(fill(8'd7), fill(8'd7), 4'd0, 8'd0, 2'b00, 3'b001, 1'b0, 32'h0, '0, 1'b0, "sub_zero");
      sb = '0; sb[2] = 8'd3; sb[0] = 8'd1;
      issue(fill(8'h81), sb, 4'd2, 8'd0, 2'b01, 3'b110, 1'b0, 32'h0, '0, 1'b0, "scalar_shl");
      issue(fill(8'h81), sb, 4'd7, 8'd0, 2'b01, 3'b110, 1'b0, 32'h0, '0, 1'b0, "scalar_idx7");
      issue(fill(8'h81), sb, 4'd6, 8'd0, 2'b01, 3'b111, 1'b0, 32'h0, '0, 1'b0, "scalar_idx6");
      issue(fill(8'd16), '0, 4'd0, 8'd17, 2'b10, 3'b010, 1'b0, 32'h0, '0, 1'b0, "mul");

      for (int i = 0; i < R; i++) wd[i] = N'(i + 1);
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b1, 32'h0000_00FE, wd, 1'b0, "wr_wrap");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_00FE, '0, 1'b0, "rd_wrapFE");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_0000, '0, 1'b0, "rd_wrap00");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b1, 32'h1234_5640, fill(8'hA5), 1'b0, "wr_40");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b1, 32'h0000_0040, fill(8'h3C), 1'b1, "rst_wr_40");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_0040, '0, 1'b0, "rd_after_rst");
      issue('0, '0, 4'd0, 8'd0, 2'b00, 3'b000, 1'b0, 32'h0000_00FE, '0, 1'b0, "rd_after_rstFE");

      last_ma = 32'h0;
      for (int t = 0; t < 400; t++) begin
         ma = ($urandom_range(0, 3) == 0) ? last_ma : I'($urandom);
         last_ma = ma;
         issue(rvec(), rvec(), 4'($urandom), N'($urandom), 2'($urandom), 3'($urandom),
               1'($urandom), ma, rvec(), ($urandom_range(0, 63) == 0), "random");
      end

      @(posedge clk);
      #1;
      tb_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
